// File: rtl/sim_test_monitor_if.sv
// Processor-side snoop bus (data-memory writes, retire strobe) plus the console byte stream.
// The processor/bench is the master; the monitor is the slave.
interface sim_test_monitor_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  retire;
    logic                  con_valid;
    logic [7:0]            con_data;
    logic                  con_ready;

    modport master (
        output mem_we, mem_addr, mem_wdata, retire, con_ready,
        input  con_valid, con_data
    );

    modport slave (
        input  mem_we, mem_addr, mem_wdata, retire, con_ready,
        output con_valid, con_data
    );
endinterface

// File: rtl/sim_test_monitor.sv
// End-of-test monitor: decides pass/fail/timeout from tohost writes, counts RUN cycles and
// retired instructions, and queues firmware console bytes into a small ready/valid FIFO.
module sim_test_monitor #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 'h0000_1000,
    parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR   = 'h0000_1004,
    parameter int                    TIMEOUT_CYCLES = 15_000_000,
    parameter int                    CNT_WIDTH      = 32,
    parameter int                    CON_DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    sim_test_monitor_if.slave     bus,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [DATA_WIDTH-2:0] fail_code,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [CNT_WIDTH-1:0]  retire_count,
    output logic                  con_overflow
);

    localparam int IDX_W = $clog2(CON_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0]     DEPTH_P      = PTR_W'(CON_DEPTH);
    // cycle_count holds the number of completed RUN cycles, so the last one sees N-1
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t state;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic                  run;
    logic                  tohost_hit;
    logic                  console_hit;
    logic                  timeout_hit;
    logic [DATA_WIDTH-2:0] wdata_hi;

    assign run         = (state == S_RUN);
    assign wdata_hi    = bus.mem_wdata[DATA_WIDTH-1:1];
    assign tohost_hit  = run && bus.mem_we && (bus.mem_addr == TOHOST_ADDR) && bus.mem_wdata[0];
    assign console_hit = run && bus.mem_we && (bus.mem_addr == CONSOLE_ADDR);
    assign timeout_hit = (cycle_count == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            fail_code    <= '0;
            cycle_count  <= '0;
            retire_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_RUN;
                end
                S_RUN: begin
                    cycle_count <= sat_inc(cycle_count);
                    if (bus.retire) retire_count <= sat_inc(retire_count);
                    // A tohost result in the final cycle takes priority over the timeout
                    if (tohost_hit && (wdata_hi == '0)) begin
                        state <= S_PASS;
                        pass  <= 1'b1;
                        done  <= 1'b1;
                    end else if (tohost_hit) begin
                        state     <= S_FAIL;
                        fail      <= 1'b1;
                        done      <= 1'b1;
                        fail_code <= wdata_hi;
                    end else if (timeout_hit) begin
                        state   <= S_TIMEOUT;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [7:0]       con_mem [CON_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] fill;
    logic [7:0]       last_byte;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;

    assign fill       = wr_ptr - rd_ptr;
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == DEPTH_P);
    assign pop        = !fifo_empty && bus.con_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign push_ok    = console_hit && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            last_byte    <= '0;
            con_overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_byte <= con_mem[rd_ptr[IDX_W-1:0]];
            end
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (console_hit && fifo_full && !pop) con_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) con_mem[wr_ptr[IDX_W-1:0]] <= bus.mem_wdata[7:0];
    end

    // When empty the output keeps showing the most recently popped byte
    assign bus.con_valid = !fifo_empty;
    assign bus.con_data  = fifo_empty ? last_byte : con_mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: doc/sim_test_monitor.md
Name: sim_test_monitor

Overview:
- Parametrised end-of-test monitor for RV32I processor simulation and FPGA bring-up.
- Replaces the fixed-delay `$finish` test-bench style with result detection from the processor itself.
- Snoops the data-memory write bus. Decides pass/fail from a tohost write, or flags a timeout.
- Counts cycles and retired instructions, and buffers console bytes written by firmware into a ready/valid FIFO.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr.
- DATA_WIDTH, 32, width of mem_wdata; must be ≥ 9.
- TOHOST_ADDR, 32'h0000_1000, word address of the result register.
- CONSOLE_ADDR, 32'h0000_1004, word address of the console byte register.
- TIMEOUT_CYCLES, 15_000_000, RUN cycles allowed before timeout; must be ≥ 2.
- CNT_WIDTH, 32, width of the cycle and retire counters.
- CON_DEPTH, 8, console FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins the RUN phase.
- mem_we  input  1  data-memory write strobe, one write per asserted cycle.
- mem_addr  input  ADDR_WIDTH  write address.
- mem_wdata  input  DATA_WIDTH  write data.
- retire  input  1  one instruction retired this cycle.
- done  output  1  test finished (pass, fail or timeout); sticky.
- pass  output  1  tohost reported success; sticky.
- fail  output  1  tohost reported failure; sticky.
- timeout  output  1  TIMEOUT_CYCLES elapsed with no result; sticky.
- fail_code  output  DATA_WIDTH-1  mem_wdata[DATA_WIDTH-1:1] of the failing tohost write.
- cycle_count  output  CNT_WIDTH  RUN cycles elapsed.
- retire_count  output  CNT_WIDTH  instructions retired during RUN.
- con_valid  output  1  console FIFO non-empty.
- con_data  output  8  head byte of the console FIFO.
- con_ready  input  1  consumer accepts the head byte when con_valid is also high.
- con_overflow  output  1  a console byte was dropped; sticky.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs and counters are 0; FIFO empty.
  - Reset mid-RUN or mid-DONE aborts the test fully, including discarding FIFO contents.
- FSM states: IDLE, RUN, PASS, FAIL, TIMEOUT.
  - IDLE→RUN on start.
  - RUN→PASS on a tohost write with wdata==1.
  - RUN→FAIL on a tohost write with wdata[0]==1 and wdata[DATA_WIDTH-1:1]!=0.
  - RUN→TIMEOUT on the TIMEOUT_CYCLES-th RUN cycle, if no terminating write occurs in that cycle.
  - PASS, FAIL and TIMEOUT are terminal until reset. start is ignored outside IDLE.
- A tohost write with wdata[0]==0 is ignored.
- All status outputs are registered and assert the cycle after the deciding edge.
- done = pass | fail | timeout. Exactly one of pass/fail/timeout is ever high.
- fail_code captures on the FAIL transition; it is 0 otherwise.
- Simultaneous tohost write and timeout cycle: the tohost result wins.
- cycle_count:
  - +1 on every RUN cycle, including the deciding cycle.
  - Frozen in terminal states.
  - Saturates at all-ones and never wraps.
  - Equals TIMEOUT_CYCLES after a timeout.
- retire_count: +1 on each RUN cycle with retire high, including the deciding cycle. Frozen, saturating.
- Writes and retire pulses outside RUN are ignored. Writes to other addresses are ignored.
- Console push:
  - Trigger: mem_we with mem_addr==CONSOLE_ADDR in RUN.
  - Pushes mem_wdata[7:0].
  - The byte is visible on con_data/con_valid the following cycle if the FIFO was empty.
- Console pop: the con_valid & con_ready cycle removes the head entry. Draining continues in terminal states.
- FIFO ordering is strict FIFO.
  - Pointer width is log2(CON_DEPTH)+1; pointers wrap modulo 2·CON_DEPTH.
- Full FIFO:
  - Push without pop drops the byte and sets con_overflow.
  - Push with pop in the same cycle accepts the byte, with no overflow.
- Empty FIFO: con_valid=0, con_data holds its last value, and pop is a no-op.

Test Plan:
(TIMEOUT_CYCLES=100, CON_DEPTH=4 unless noted)
1. Reset, start, 10 RUN cycles with retire high on 7 of them, then tohost write 32'h1 → next cycle pass=1, done=1, fail=0, cycle_count=11, retire_count=7 (8 if retire is also high on the deciding cycle); counters stay frozen for 20 further cycles.
2. start, then tohost write 32'h0000_002B → fail=1, fail_code=21, pass=0; a later tohost write 32'h1 does not change any output.
3. start, then no tohost write → timeout=1 exactly 100 cycles after RUN entry, cycle_count=100. Repeat with a tohost 32'h1 write on cycle 100 → pass=1, timeout=0.
4. start, write "H","i","!" to CONSOLE_ADDR with con_ready=0 → con_valid=1, con_data="H". Raise con_ready → bytes appear in order "H","i","!", then con_valid=0; con_overflow=0.
5. con_ready=0, 5 console writes → 4 bytes held, con_overflow=1. Refill to full, then a push and pop in the same cycle → byte accepted, FIFO count stays 4.
6. Assert rst_n low mid-RUN with 2 bytes queued and cycle_count=50 → immediately all outputs 0, con_valid=0; a write before the next start is ignored.
